win3x3_linebuf: RTL and testbench

- Upstream stage of the 3x3 median filter and other 3x3 neighbourhood filters.
- Takes an 8-bit raster pixel stream with hsync/vsync/de, keeps the two previous lines in on-chip line buffers, and presents a 3x3 window every active pixel.
- Missing rows and columns at the top and left image border are filled by replication.
- Sync signals are delayed to stay aligned with the window.

---
 rtl/win3x3_linebuf_pkg.sv | 26 ++
 rtl/win3x3_linebuf_ram.sv | 30 +++
 rtl/win3x3_linebuf.sv | 225 ++++++++++++++++++++++
 tb/tb_win3x3_linebuf.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win3x3_linebuf_pkg.sv
// Shared pixel-pipeline constants and the saturating row-phase type used by
// the 3x3 window line buffer.
package win3x3_linebuf_pkg;

  localparam int unsigned LB_DW         = 8;
  localparam int unsigned LB_IMG_WIDTH  = 640;
  localparam int unsigned LB_IMG_HEIGHT = 480;
  localparam int unsigned LB_SYNC_DLY   = 2;

  // Only "first line", "second line" and "two or more lines" matter for
  // vertical replication, so the row counter saturates at ROW_2.
  typedef enum logic [1:0] {
    ROW_0 = 2'd0,
    ROW_1 = 2'd1,
    ROW_2 = 2'd2
  } row_e;

  function automatic row_e row_next(input row_e r);
    case (r)
      ROW_0:   row_next = ROW_1;
      ROW_1:   row_next = ROW_2;
      default: row_next = ROW_2;
    endcase
  endfunction

endpackage

// File: rtl/win3x3_linebuf_ram.sv
// Simple dual-port line RAM: one write port, one registered read port,
// read-first when both ports hit the same address.
module linebuf_ram
  import win3x3_linebuf_pkg::*;
#(
  parameter int unsigned DEPTH = LB_IMG_WIDTH,
  parameter int unsigned DW    = LB_DW,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/win3x3_linebuf.sv
// 3x3 neighbourhood window generator: two cascaded line buffers, top/left
// border replication and a fixed 2-cycle sync delay.
module win3x3_linebuf
  import win3x3_linebuf_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = LB_IMG_WIDTH,
  parameter int unsigned DW        = LB_DW,
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          de_i,
  input  logic [DW-1:0] data_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [DW-1:0] a0,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] b0,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] c0,
  output logic [DW-1:0] c1,
  output logic [DW-1:0] c2,
  output logic          line_ovf_o
);

  localparam int unsigned SD = LB_SYNC_DLY;

  // One window column: [2] = oldest row (a), [1] = previous row (b), [0] = current row (c)
  typedef logic [2:0][DW-1:0] col_t;

  logic [SD-1:0] r_hs_sr;
  logic [SD-1:0] r_vs_sr;
  logic [SD-1:0] r_de_sr;

  logic          r_de_d;
  logic          r_vs_d;
  logic [CW-1:0] r_col;
  logic          r_col_full;
  row_e          r_row;
  logic          r_ovf;

  logic [DW-1:0] r_pix1;
  logic [CW-1:0] r_col1;
  row_e          r_row1;
  logic          r_wr1;

  col_t          r_x0;
  col_t          r_x1;
  col_t          r_x2;

  logic          w_de_fall;
  logic          w_vs_rise;
  logic          w_col_last;
  logic          w_ovf_pix;
  logic [DW-1:0] w_lb1_q;
  logic [DW-1:0] w_lb2_q;
  col_t          w_new;

  assign w_de_fall  = r_de_d & ~de_i;
  assign w_vs_rise  = vsync_i & ~r_vs_d;
  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_ovf_pix  = de_i & r_col_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_sr <= '0;
      r_vs_sr <= '0;
      r_de_sr <= '0;
      r_de_d  <= 1'b0;
      r_vs_d  <= 1'b0;
    end else begin
      r_hs_sr <= {r_hs_sr[SD-2:0], hsync_i};
      r_vs_sr <= {r_vs_sr[SD-2:0], vsync_i};
      r_de_sr <= {r_de_sr[SD-2:0], de_i};
      r_de_d  <= de_i;
      r_vs_d  <= vsync_i;
    end
  end

  // r_col_full marks that the last column already took a pixel; any further
  // pixel on the same line is an overflow and must not touch the RAMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_col_full <= 1'b0;
    end else if (!de_i) begin
      r_col      <= '0;
      r_col_full <= 1'b0;
    end else if (w_col_last) begin
      r_col_full <= 1'b1;
    end else begin
      r_col <= r_col + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= ROW_0;
    end else if (w_vs_rise) begin
      r_row <= ROW_0;
    end else if (w_de_fall) begin
      r_row <= row_next(r_row);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_vs_rise) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_pix) begin
      r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix1 <= '0;
      r_col1 <= '0;
      r_row1 <= ROW_0;
      r_wr1  <= 1'b0;
    end else begin
      r_wr1 <= de_i & ~w_ovf_pix;
      if (de_i) begin
        r_pix1 <= data_i;
        r_col1 <= r_col;
        r_row1 <= r_row;
      end
    end
  end

  linebuf_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW),
    .AW    (CW)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (de_i & ~w_ovf_pix),
    .i_waddr (r_col),
    .i_wdata (data_i),
    .i_re    (de_i),
    .i_raddr (r_col),
    .o_rdata (w_lb1_q)
  );

  // lb2 is fed one cycle later with the value lb1 held before it was
  // overwritten, which is only available once lb1's registered read returns.
  linebuf_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW),
    .AW    (CW)
  ) u_lb2 (
    .clk     (clk),
    .i_we    (r_wr1),
    .i_waddr (r_col1),
    .i_wdata (w_lb1_q),
    .i_re    (de_i),
    .i_raddr (r_col),
    .o_rdata (w_lb2_q)
  );

  always_comb begin
    w_new    = '0;
    w_new[0] = r_pix1;
    case (r_row1)
      ROW_0: begin
        w_new[1] = r_pix1;
        w_new[2] = r_pix1;
      end
      ROW_1: begin
        w_new[1] = w_lb1_q;
        w_new[2] = w_lb1_q;
      end
      default: begin
        w_new[1] = w_lb1_q;
        w_new[2] = w_lb2_q;
      end
    endcase
  end

  // Vertical replication is folded into each new column; columns already in
  // the window come from the same line, so they are replicated consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (r_de_sr[0]) begin
      if (r_col1 == '0) begin
        r_x0 <= w_new;
        r_x1 <= w_new;
        r_x2 <= w_new;
      end else if (r_col1 == CW'(1)) begin
        r_x0 <= r_x2;
        r_x1 <= r_x2;
        r_x2 <= w_new;
      end else begin
        r_x0 <= r_x1;
        r_x1 <= r_x2;
        r_x2 <= w_new;
      end
    end
  end

  assign hsync_o    = r_hs_sr[SD-1];
  assign vsync_o    = r_vs_sr[SD-1];
  assign de_o       = r_de_sr[SD-1];
  assign line_ovf_o = r_ovf;

  assign a0 = r_x0[2];
  assign a1 = r_x1[2];
  assign a2 = r_x2[2];
  assign b0 = r_x0[1];
  assign b1 = r_x1[1];
  assign b2 = r_x2[1];
  assign c0 = r_x0[0];
  assign c1 = r_x1[0];
  assign c2 = r_x2[0];

endmodule

// File: tb/tb_win3x3_linebuf.sv
// Bench for win3x3_linebuf: a frame-level model (pixels stored per line,
// window = clamped neighbourhood) checked every cycle, plus literal windows.
module tb_win3x3_linebuf;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_i = 1'b0;
  logic       vsync_i = 1'b0;
  logic       de_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       hsync_o, vsync_o, de_o, line_ovf_o;
  logic [7:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
  logic [71:0] w_dut;

  win3x3_linebuf #(
    .IMG_WIDTH (W),
    .DW        (8),
    .CW        (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .de_i       (de_i),
    .data_i     (data_i),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .de_o       (de_o),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .c0         (c0),
    .c1         (c1),
    .c2         (c2),
    .line_ovf_o (line_ovf_o)
  );

  always #5 clk = ~clk;

  assign w_dut = {a0, a1, a2, b0, b1, b2, c0, c1, c2};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [71:0] rows(input logic [23:0] ra, input logic [23:0] rb,
                                       input logic [23:0] rc);
    return {ra, rb, rc};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        hs, vs, de, wk;
    logic [71:0] win;
  } rec_t;

  logic [7:0]  img [0:63][0:W-1];
  int          m_col = 0;
  bit          m_full = 0;
  int          m_line = 0;
  bit          m_de_prev = 0;
  bit          m_vs_prev = 0;
  rec_t        s1 = '{hs: 1'b0, vs: 1'b0, de: 1'b0, wk: 1'b1, win: '0};
  logic        e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_ovf = 1'b0, e_wk = 1'b1;
  logic [71:0] e_win = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_col = 0; m_full = 0; m_line = 0; m_de_prev = 0; m_vs_prev = 0;
        s1 = '{hs: 1'b0, vs: 1'b0, de: 1'b0, wk: 1'b1, win: '0};
        e_hs = 0; e_vs = 0; e_de = 0; e_ovf = 0; e_wk = 1; e_win = '0;
      end else begin
        rec_t nr;
        bit   vs_rise, de_fall, full_before;
        e_hs = s1.hs; e_vs = s1.vs; e_de = s1.de;
        if (s1.de) begin
          e_win = s1.win;
          e_wk  = s1.wk;
        end
        nr = '{hs: hsync_i, vs: vsync_i, de: de_i, wk: 1'b1, win: '0};
        full_before = m_full;
        if (de_i) begin
          if (!full_before) img[m_line % 64][m_col] = data_i;
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              int lr, cc;
              lr = m_line - 2 + i; if (lr < 0) lr = 0;
              cc = m_col - 2 + j;  if (cc < 0) cc = 0;
              nr.win[(8 - (i * 3 + j)) * 8 +: 8] = img[lr % 64][cc];
            end
          end
          nr.wk = !full_before;
          if (m_col < W - 1) m_col++;
          else m_full = 1;
        end else begin
          m_col = 0;
          m_full = 0;
        end
        vs_rise = vsync_i && !m_vs_prev;
        de_fall = m_de_prev && !de_i;
        if (vs_rise) begin
          m_line = 0;
          e_ovf  = 0;
        end else begin
          if (de_fall) m_line++;
          if (de_i && full_before) e_ovf = 1;
        end
        m_de_prev = de_i;
        m_vs_prev = vsync_i;
        s1 = nr;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [71:0] win_log[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("de_o", 72'(de_o), 72'(e_de));
      chk("hsync_o", 72'(hsync_o), 72'(e_hs));
      chk("vsync_o", 72'(vsync_o), 72'(e_vs));
      chk("line_ovf_o", 72'(line_ovf_o), 72'(e_ovf));
      if (e_wk) chk("window", w_dut, e_win);
      if (de_o === 1'b1) win_log.push_back(w_dut);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic hs, input logic vs, input logic de, input logic [7:0] d);
    @(posedge clk);
    #2;
    hsync_i = hs; vsync_i = vs; de_i = de; data_i = d;
  endtask

  task automatic vpulse();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // mode 0: base+k, 1: constant base, other: random
  task automatic send_line(input int n, input int gap, input int mode, input int base);
    for (int k = 0; k < n; k++) begin
      logic [7:0] d;
      case (mode)
        0:       d = 8'(base + k);
        1:       d = 8'(base);
        default: d = 8'($urandom_range(0, 255));
      endcase
      drive(1'b0, 1'b0, 1'b1, d);
    end
    for (int g = 0; g < gap; g++) drive(g == 0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fresh_log();
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    win_log.delete();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [71:0] exp);
    if (idx < win_log.size()) begin
      chk(nm, win_log[idx], exp);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: window %0d not produced (only %0d), required %h", nm, idx,
               win_log.size(), exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {60'(0), hsync_o, vsync_o, de_o, line_ovf_o, 8'(0)}, '0);
    chk("reset_window", w_dut, '0);
    @(posedge clk); #2; rst_n = 1'b1;

    // 4x3 frame, pixels 1..12
    vpulse();
    fresh_log();
    for (int r = 0; r < 3; r++) send_line(W, 2, 0, r * W + 1);
    fresh_log_keep: begin
      repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk_log("win_r0c0", 0, {9{8'd1}});
    chk_log("win_r0c3", 3, rows({8'd2, 8'd3, 8'd4}, {8'd2, 8'd3, 8'd4}, {8'd2, 8'd3, 8'd4}));
    chk_log("win_r1c1", 5, rows({8'd1, 8'd1, 8'd2}, {8'd1, 8'd1, 8'd2}, {8'd5, 8'd5, 8'd6}));
    chk_log("win_r2c2", 10, rows({8'd1, 8'd2, 8'd3}, {8'd5, 8'd6, 8'd7}, {8'd9, 8'd10, 8'd11}));

    // overflow: 6 pixels on a 4-wide line
    vpulse();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(100 + k));
      if (k == 4) begin #1; chk("ovf_before_5th", 72'(line_ovf_o), 72'(0)); end
      if (k == 5) begin #1; chk("ovf_after_5th", 72'(line_ovf_o), 72'(1)); end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    fresh_log();
    send_line(W, 2, 0, 50);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("ovf_sticky", 72'(line_ovf_o), 72'(1));
    chk_log("ovf_lb1_first4", 3,
            rows({8'd101, 8'd102, 8'd103}, {8'd101, 8'd102, 8'd103}, {8'd51, 8'd52, 8'd53}));
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    #1;
    chk("ovf_clear_vsync", 72'(line_ovf_o), 72'(0));
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // frame restart: old frame data must not leak into a new frame
    vpulse();
    send_line(W, 2, 2, 0);
    send_line(W, 2, 2, 0);
    vpulse();
    fresh_log();
    send_line(W, 2, 1, 200);
    send_line(W, 2, 1, 200);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < W; k++) chk_log("restart_200", k, {9{8'd200}});

    // back-to-back lines with single-cycle gaps
    vpulse();
    for (int r = 0; r < 5; r++) send_line(W, 1, 2, 0);

    // reset in the middle of row 2
    vpulse();
    send_line(W, 2, 2, 0);
    send_line(W, 2, 2, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd31);
    drive(1'b0, 1'b0, 1'b1, 8'd32);
    @(posedge clk); #2;
    de_i = 1'b1; data_i = 8'd33; rst_n = 1'b0;
    #1;
    chk("midline_reset_sync", {68'(0), hsync_o, vsync_o, de_o, line_ovf_o}, '0);
    chk("midline_reset_win", w_dut, '0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #2; rst_n = 1'b1;
    fresh_log();
    send_line(W, 2, 0, 77);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk_log("post_reset_c0", 0, {9{8'd77}});
    chk_log("post_reset_c1", 1, rows({8'd77, 8'd77, 8'd78}, {8'd77, 8'd77, 8'd78}, {8'd77, 8'd77, 8'd78}));

    // random frames
    for (int f = 0; f < 8; f++) begin
      int fw, nl, gap;
      fw  = $urandom_range(1, W);
      nl  = $urandom_range(1, 5);
      gap = $urandom_range(1, 3);
      vpulse();
      for (int r = 0; r < nl; r++) begin
        int len;
        len = fw;
        if (fw == W && $urandom_range(0, 3) == 0) len = fw + $urandom_range(1, 2);
        send_line(len, gap, 2, 0);
      end
    end

    repeat (6) drive(1'b0, 1'b0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
